// File: rtl/wb_regfile.sv
// Register file for the ID/WB stages: two combinational read ports, one write-back port.
// Optional macro WB_REGFILE_BYPASS_EN forwards a same-cycle commit onto matching read ports.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUout_i,
    input  logic [DATA_W-1:0] Memout_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o
);

    localparam int unsigned REG_N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [REG_N];
    logic              commit;
    logic [DATA_W-1:0] rs1_array;
    logic [DATA_W-1:0] rs2_array;

    // Write-back source mux and commit qualifier; index 0 is never written.
    always_comb begin
        wb_data_o = MemtoReg_i ? Memout_i : ALUout_i;
        commit    = RegWrite_i && (rd_addr_i != '0);
    end

    // Array and write-back status; reset overrides any simultaneous commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs[i] <= '0;
            end
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
        end else begin
            if (commit) begin
                regs[rd_addr_i] <= wb_data_o;
                wb_addr_o       <= rd_addr_i;
            end
            wb_valid_o <= commit;
        end
    end

    always_comb begin
        rs1_array = (rs1_addr_i == '0) ? '0 : regs[rs1_addr_i];
        rs2_array = (rs2_addr_i == '0) ? '0 : regs[rs2_addr_i];
    end

`ifdef WB_REGFILE_BYPASS_EN
    // commit already excludes index 0; reset suppresses forwarding.
    always_comb begin
        rs1_data_o = rs1_array;
        rs2_data_o = rs2_array;
        if (!rst_i && commit && (rd_addr_i == rs1_addr_i)) begin
            rs1_data_o = wb_data_o;
        end
        if (!rst_i && commit && (rd_addr_i == rs2_addr_i)) begin
            rs2_data_o = wb_data_o;
        end
    end
`else
    always_comb begin
        rs1_data_o = rs1_array;
        rs2_data_o = rs2_array;
    end
`endif

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: DATA_W, 32, register and data width in bits.
REQ-002 Parameter: ADDR_W, 5, register address width; register count = 2**ADDR_W.
REQ-003 clk_i  in  1  clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 RegWrite_i  in  1  write-back enable from MEM/WB stage.
REQ-006 MemtoReg_i  in  1  write-back source select: 1 = Memout_i, 0 = ALUout_i.
REQ-007 ALUout_i  in  DATA_W  ALU result from MEM/WB stage.
REQ-008 Memout_i  in  DATA_W  load data from MEM/WB stage.
REQ-009 rd_addr_i  in  ADDR_W  destination register index.
REQ-010 rs1_addr_i  in  ADDR_W  read port 1 index (ID stage).
REQ-011 rs2_addr_i  in  ADDR_W  read port 2 index (ID stage).
REQ-012 rs1_data_o  out  DATA_W  read port 1 data, combinational.
REQ-013 rs2_data_o  out  DATA_W  read port 2 data, combinational.
REQ-014 wb_data_o  out  DATA_W  selected write-back value, combinational; feeds EX forwarding.
REQ-015 wb_valid_o  out  1  registered; 1 for one cycle after a committed write to a nonzero rd.
REQ-016 wb_addr_o  out  ADDR_W  registered; index of the last committed write.

Function
REQ-017 wb_data_o = MemtoReg_i ? Memout_i : ALUout_i, every cycle regardless of RegWrite_i.
REQ-018 Commit: on posedge with rst_i=0, RegWrite_i=1, rd_addr_i!=0 -> reg[rd_addr_i] <= wb_data_o.
REQ-019 Write to index 0 is discarded; reg[0] always reads 0.
REQ-020 RegWrite_i=0 -> no array change.
REQ-021 Read: rsN_data_o = reg[rsN_addr_i], zero latency; index 0 -> 0.
REQ-022 Both read ports are independent and may address the same register.
REQ-023 wb_valid_o <= RegWrite_i && rd_addr_i!=0; wb_addr_o <= rd_addr_i when committing, else hold.
REQ-024 Commit in cycle N is visible on read ports from cycle N+1 (array path) without bypass.
REQ-025 Back-to-back writes to the same rd: last write wins, one commit per cycle.
REQ-026 X/undriven inputs while RegWrite_i=0 do not corrupt the array.

Reset
REQ-027 rst_i=1 at posedge: all registers <= 0, wb_valid_o <= 0, wb_addr_o <= 0.
REQ-028 Reset dominates a simultaneous write; the write is lost.
REQ-029 Read ports return 0 for all indices in the cycle after reset; reset mid-sequence discards all prior commits.

Configuration
REQ-030 Macro WB_REGFILE_BYPASS_EN defined: if RegWrite_i=1, rd_addr_i!=0, rd_addr_i==rsN_addr_i, rst_i=0, then rsN_data_o = wb_data_o in the same cycle.
REQ-031 Macro undefined: no bypass; read ports show array contents only (REQ-024 timing); ID-stage hazard handling is the pipeline's responsibility.
REQ-032 Bypass never applies to index 0, nor while rst_i=1.

Verification
REQ-033 Reset 2 cycles, read rs1=5, rs2=31 -> both 0; wb_valid_o=0, wb_addr_o=0.
REQ-034 RegWrite=1, MemtoReg=0, ALUout=0x12345678, rd=7; next cycle rs1=7 -> 0x12345678, wb_valid_o=1, wb_addr_o=7.
REQ-035 RegWrite=1, MemtoReg=1, Memout=0xDEADBEEF, rd=0 -> rs1=0 reads 0, wb_valid_o=0, wb_addr_o unchanged.
REQ-036 Same cycle write rd=3 value 0xA5A5A5A5, rs2=3, old reg[3]=0x1: with WB_REGFILE_BYPASS_EN rs2_data_o=0xA5A5A5A5 in that cycle; without, 0x1 then 0xA5A5A5A5 next cycle.
REQ-037 rst_i=1 together with RegWrite=1, rd=9, ALUout=0xFFFFFFFF -> next cycle reg[9]=0, wb_valid_o=0.
REQ-038 Writes rd=4 0x11 then rd=4 0x22 in consecutive cycles -> rs1=rs2=4 reads 0x22 afterwards; wb_data_o tracks MemtoReg toggling combinationally.
